// File: rtl/aes_avl_pkg.sv
// Shared constants, state encoding and word helpers for the Avalon-MM AES decryption host.
package aes_avl_pkg;

  localparam logic [3:0] AES_KEY_BASE    = 4'd0;
  localparam logic [3:0] AES_MSG_EN_BASE = 4'd4;
  localparam logic [3:0] AES_MSG_DE_BASE = 4'd8;
  localparam logic [3:0] AES_START_ADDR  = 4'd14;
  localparam logic [3:0] AES_DONE_ADDR   = 4'd15;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned LAT_W   = 2;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_KEY    = 4'd1,
    WR_MSG    = 4'd2,
    WR_START  = 4'd3,
    POLL_RD   = 4'd4,
    POLL_WAIT = 4'd5,
    RD_MSG    = 4'd6,
    CLR_START = 4'd7,
    RESP      = 4'd8
  } host_state_t;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [IDX_W-1:0]   idx);
    logic [WORD_W-1:0] w;
    case (idx)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/avalon_aes_host.sv
// Avalon-MM master that loads key/ciphertext into the AES register file, starts it,
// polls Done, reads back the plaintext and returns it on a valid/ready response port.
module avalon_aes_host
  import aes_avl_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned POLL_GAP     = 2,
  parameter int unsigned POLL_LIMIT   = 1024
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [BLOCK_W-1:0]  CMD_KEY,
  input  logic [BLOCK_W-1:0]  CMD_MSG,
  output logic                RSP_VALID,
  input  logic                RSP_READY,
  output logic [BLOCK_W-1:0]  RSP_DATA,
  output logic                RSP_TIMEOUT,
  output logic                BUSY,
  output logic                AVL_CS,
  output logic                AVL_READ,
  output logic                AVL_WRITE,
  output logic [3:0]          AVL_ADDR,
  output logic [3:0]          AVL_BYTE_EN,
  output logic [WORD_W-1:0]   AVL_WRITEDATA,
  input  logic [WORD_W-1:0]   AVL_READDATA
);

  localparam int unsigned PCNT_W = $clog2(POLL_LIMIT + 1);
  localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  host_state_t          state, state_n;
  logic [IDX_W-1:0]     beat, beat_n;
  logic [LAT_W-1:0]     lat_cnt, lat_n;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic [PCNT_W-1:0]    poll_cnt, poll_n, poll_inc;
  logic [BLOCK_W-1:0]   key_q, key_n, msg_q, msg_n, pt_q, pt_n;
  logic                 timeout_q, to_n;
  logic                 rd_last;

  logic                 cmd_ready_n, rsp_valid_n, rsp_to_n, busy_n;
  logic [BLOCK_W-1:0]   rsp_data_n;
  logic                 cs_n, rd_n, wr_n;
  logic [3:0]           addr_n;
  logic [WORD_W-1:0]    wdata_n;

  // Next-state, datapath and next-output logic; outputs follow the next state so they register in step.
  always_comb begin
    state_n     = state;
    beat_n      = beat;
    lat_n       = lat_cnt;
    gap_n       = gap_cnt;
    poll_n      = poll_cnt;
    key_n       = key_q;
    msg_n       = msg_q;
    pt_n        = pt_q;
    to_n        = timeout_q;
    rsp_valid_n = RSP_VALID;
    rsp_data_n  = RSP_DATA;
    rsp_to_n    = RSP_TIMEOUT;
    rd_last     = (lat_cnt == LAT_W'(READ_LATENCY));
    poll_inc    = poll_cnt + PCNT_W'(1);

    case (state)
      IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          key_n   = CMD_KEY;
          msg_n   = CMD_MSG;
          beat_n  = '0;
          poll_n  = '0;
          to_n    = 1'b0;
          state_n = WR_KEY;
        end
      end
      WR_KEY: begin
        if (beat == IDX_W'(WORDS - 1)) begin
          beat_n  = '0;
          state_n = WR_MSG;
        end else begin
          beat_n = beat + IDX_W'(1);
        end
      end
      WR_MSG: begin
        if (beat == IDX_W'(WORDS - 1)) begin
          beat_n  = '0;
          state_n = WR_START;
        end else begin
          beat_n = beat + IDX_W'(1);
        end
      end
      WR_START: begin
        lat_n   = '0;
        state_n = POLL_RD;
      end
      POLL_RD: begin
        if (rd_last) begin
          poll_n = poll_inc;
          lat_n  = '0;
          if (AVL_READDATA[0]) begin
            beat_n  = '0;
            state_n = RD_MSG;
          end else if (poll_inc == PCNT_W'(POLL_LIMIT)) begin
            to_n    = 1'b1;
            state_n = CLR_START;
          end else if (POLL_GAP == 0) begin
            state_n = POLL_RD;
          end else begin
            gap_n   = '0;
            state_n = POLL_WAIT;
          end
        end else begin
          lat_n = lat_cnt + LAT_W'(1);
        end
      end
      POLL_WAIT: begin
        if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
          lat_n   = '0;
          state_n = POLL_RD;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      RD_MSG: begin
        if (rd_last) begin
          pt_n  = {pt_q[BLOCK_W-WORD_W-1:0], AVL_READDATA};
          lat_n = '0;
          if (beat == IDX_W'(WORDS - 1)) state_n = CLR_START;
          else                           beat_n  = beat + IDX_W'(1);
        end else begin
          lat_n = lat_cnt + LAT_W'(1);
        end
      end
      CLR_START: begin
        rsp_valid_n = 1'b1;
        rsp_data_n  = timeout_q ? '0 : pt_q;
        rsp_to_n    = timeout_q;
        state_n     = RESP;
      end
      RESP: begin
        if (RSP_VALID && RSP_READY) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    rd_n    = 1'b0;
    wr_n    = 1'b0;
    addr_n  = '0;
    wdata_n = '0;
    case (state_n)
      WR_KEY: begin
        wr_n    = 1'b1;
        addr_n  = AES_KEY_BASE + 4'(beat_n);
        wdata_n = block_word(key_n, beat_n);
      end
      WR_MSG: begin
        wr_n    = 1'b1;
        addr_n  = AES_MSG_EN_BASE + 4'(beat_n);
        wdata_n = block_word(msg_n, beat_n);
      end
      WR_START: begin
        wr_n    = 1'b1;
        addr_n  = AES_START_ADDR;
        wdata_n = 32'h1;
      end
      POLL_RD: begin
        rd_n   = 1'b1;
        addr_n = AES_DONE_ADDR;
      end
      RD_MSG: begin
        rd_n   = 1'b1;
        addr_n = AES_MSG_DE_BASE + 4'(beat_n);
      end
      CLR_START: begin
        wr_n   = 1'b1;
        addr_n = AES_START_ADDR;
      end
      default: ;
    endcase
    cs_n        = rd_n | wr_n;
    cmd_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state         <= IDLE;
      beat          <= '0;
      lat_cnt       <= '0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      key_q         <= '0;
      msg_q         <= '0;
      pt_q          <= '0;
      timeout_q     <= 1'b0;
      CMD_READY     <= 1'b0;
      RSP_VALID     <= 1'b0;
      RSP_DATA      <= '0;
      RSP_TIMEOUT   <= 1'b0;
      BUSY          <= 1'b0;
      AVL_CS        <= 1'b0;
      AVL_READ      <= 1'b0;
      AVL_WRITE     <= 1'b0;
      AVL_ADDR      <= '0;
      AVL_BYTE_EN   <= '0;
      AVL_WRITEDATA <= '0;
    end else begin
      state         <= state_n;
      beat          <= beat_n;
      lat_cnt       <= lat_n;
      gap_cnt       <= gap_n;
      poll_cnt      <= poll_n;
      key_q         <= key_n;
      msg_q         <= msg_n;
      pt_q          <= pt_n;
      timeout_q     <= to_n;
      CMD_READY     <= cmd_ready_n;
      RSP_VALID     <= rsp_valid_n;
      RSP_DATA      <= rsp_data_n;
      RSP_TIMEOUT   <= rsp_to_n;
      BUSY          <= busy_n;
      AVL_CS        <= cs_n;
      AVL_READ      <= rd_n;
      AVL_WRITE     <= wr_n;
      AVL_ADDR      <= addr_n;
      AVL_BYTE_EN   <= cs_n ? 4'hF : 4'h0;
      AVL_WRITEDATA <= wdata_n;
    end
  end

endmodule

// File: tb/tb_avalon_aes_host.sv
// Bench for avalon_aes_host: two hosts (read latency 0 and 2) each driving a behavioural AES slave.
module tb_avalon_aes_host;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  typedef struct { int cyc; logic wr; logic [3:0] addr; logic [31:0] data; } ev_t;
  typedef struct { logic [127:0] pt; logic to; } exp_t;

  logic         clk = 1'b0;
  logic         srst;
  logic         rst_n [2];
  logic         cmd_valid [2], cmd_ready [2], rsp_valid [2], rsp_ready [2], rsp_timeout [2], busy [2];
  logic         cs [2], rd [2], wr [2];
  logic [127:0] cmd_key [2], cmd_msg [2], rsp_data [2];
  logic [3:0]   addr [2], be [2];
  logic [31:0]  wdata [2], rdata [2];
  int           done_delay [2];

  int   cyc = 0, n_checks = 0, n_fail = 0, bad_inv = 0, cur = 0;
  ev_t  tr [$];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  // Stand-in decryptor: the FIPS-197 vector decrypts correctly, anything else maps through a fixed mix.
  function automatic logic [127:0] model_dec(input logic [127:0] key, input logic [127:0] msg);
    if (key == FIPS_KEY && msg == FIPS_CT) return FIPS_PT;
    return key ^ {msg[63:0], msg[127:64]} ^ 128'h5a5a_0f0f_3c3c_9696_a5a5_f0f0_c3c3_6969;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int unsigned RL = (g == 0) ? 0 : 2;
    localparam int unsigned PL = (g == 0) ? 4 : 16;
    logic [31:0]  regs [16];
    logic [31:0]  rd_d1, rd_d2;
    logic [127:0] pt;
    int           done_cnt;

    avalon_aes_host #(.READ_LATENCY(RL), .POLL_GAP(2), .POLL_LIMIT(PL)) dut (
      .CLK(clk), .RESET(rst_n[g]),
      .CMD_VALID(cmd_valid[g]), .CMD_READY(cmd_ready[g]), .CMD_KEY(cmd_key[g]), .CMD_MSG(cmd_msg[g]),
      .RSP_VALID(rsp_valid[g]), .RSP_READY(rsp_ready[g]), .RSP_DATA(rsp_data[g]),
      .RSP_TIMEOUT(rsp_timeout[g]), .BUSY(busy[g]),
      .AVL_CS(cs[g]), .AVL_READ(rd[g]), .AVL_WRITE(wr[g]), .AVL_ADDR(addr[g]),
      .AVL_BYTE_EN(be[g]), .AVL_WRITEDATA(wdata[g]), .AVL_READDATA(rdata[g])
    );

    assign pt       = model_dec({regs[0], regs[1], regs[2], regs[3]}, {regs[4], regs[5], regs[6], regs[7]});
    assign rdata[g] = !rd[g] ? 32'hdead_beef : ((RL == 0) ? regs[addr[g]] : rd_d2);

    // Register file with Done raised done_delay cycles after Start (0: with the Start write, -1: never).
    always @(posedge clk) begin
      rd_d1 <= regs[addr[g]];
      rd_d2 <= rd_d1;
      if (srst) begin
        for (int i = 0; i < 16; i++) regs[i] <= '0;
        done_cnt <= -1;
      end else if (cs[g] && wr[g]) begin
        regs[addr[g]] <= wdata[g];
        if (addr[g] == 4'd14) begin
          regs[15] <= 32'(done_delay[g] == 0 && wdata[g][0]);
          if (done_delay[g] == 0 && wdata[g][0]) begin
            regs[8]  <= pt[127:96];
            regs[9]  <= pt[95:64];
            regs[10] <= pt[63:32];
            regs[11] <= pt[31:0];
          end
          done_cnt <= wdata[g][0] ? done_delay[g] : -1;
        end
      end else if (done_cnt > 0) begin
        done_cnt <= done_cnt - 1;
        if (done_cnt == 1) begin
          regs[15] <= 32'h1;
          regs[8]  <= pt[127:96];
          regs[9]  <= pt[95:64];
          regs[10] <= pt[63:32];
          regs[11] <= pt[31:0];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle, sample just after the edge, and log bus activity of the host under test.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++)
      if ((rd[d] && wr[d]) || ((rd[d] || wr[d]) && !cs[d]) || (be[d] !== (cs[d] ? 4'hF : 4'h0)))
        bad_inv++;
    if (cs[cur]) tr.push_back('{cyc, wr[cur], addr[cur], wdata[cur]});
  endtask

  task automatic send(input int d, input logic [127:0] key, input logic [127:0] msg,
                      input logic to, output int acc);
    int n = 0;
    cur = d;
    tr.delete();
    cmd_key[d] = key;
    cmd_msg[d] = msg;
    cmd_valid[d] = 1'b1;
    while (!cmd_ready[d] && n < 50) begin tick(); n++; end
    check("cmd_ready_wait", cmd_ready[d], 1);
    acc = cyc;
    sb_q.push_back('{to ? 128'd0 : model_dec(key, msg), to});
    tick();
    cmd_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, input int max, output int at);
    int n = 0;
    while (!rsp_valid[d] && n < max) begin tick(); n++; end
    check("rsp_valid_wait", rsp_valid[d], 1);
    at = cyc;
  endtask

  task automatic take_rsp(input int d);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb_q.pop_front();
    check("rsp_data", rsp_data[d], e.pt);
    check("rsp_timeout", rsp_timeout[d], e.to);
    rsp_ready[d] = 1'b1;
    tick();
    rsp_ready[d] = 1'b0;
    check("rsp_drop", {rsp_valid[d], busy[d]}, 0);
  endtask

  function automatic logic [31:0] map_exp(input int i);
    int a;
    logic w;
    w = (i < 9) || (i == 14);
    if (i < 8)                 a = i;
    else if (i == 8 || i == 14) a = 14;
    else if (i == 9)           a = 15;
    else                       a = 8 + (i - 10);
    return {16'(i + 1), 11'd0, w, 4'(a)};
  endfunction

  function automatic logic [35:0] fips_wr_exp(input int n, input logic [127:0] k, input logic [127:0] m);
    if (n < 4)  return {4'(n), k[(3 - n) * 32 +: 32]};
    if (n < 8)  return {4'(n), m[(7 - n) * 32 +: 32]};
    if (n == 8) return {4'd14, 32'd1};
    return {4'd14, 32'd0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, at, n, clr, run, pa, pcy, last_poll;
    int pc [$];
    int runs [$];
    logic [127:0] held, k, m, kb, mb;

    srst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; cmd_valid[d] = 1'b0; rsp_ready[d] = 1'b0;
      cmd_key[d] = '0; cmd_msg[d] = '0; done_delay[d] = 0;
    end
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      check("reset_ctrl", {cmd_ready[d], rsp_valid[d], rsp_timeout[d], busy[d], cs[d], rd[d], wr[d]}, 0);
      check("reset_bus", {addr[d], be[d], wdata[d]}, 0);
      check("reset_rsp_data", rsp_data[d], 0);
    end
    srst = 1'b0;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();
    check("idle_ready", {cmd_ready[0], cmd_ready[1]}, 2'b11);

    // Done already set at first poll: exact cycle map, 16 cycles to response.
    done_delay[0] = 0;
    k = {$urandom, $urandom, $urandom, $urandom};
    m = {$urandom, $urandom, $urandom, $urandom};
    send(0, k, m, 1'b0, acc);
    wait_rsp(0, 60, at);
    check("latency16", at - acc, 16);
    check("map_len", tr.size(), 15);
    for (int i = 0; i < 15 && i < tr.size(); i++)
      check("map_ev", {16'(tr[i].cyc - acc), 11'd0, tr[i].wr, tr[i].addr}, map_exp(i));
    take_rsp(0);

    // FIPS-197 vector, Done 5 cycles after Start.
    done_delay[0] = 5;
    send(0, FIPS_KEY, FIPS_CT, 1'b0, acc);
    wait_rsp(0, 80, at);
    k = FIPS_KEY; m = FIPS_CT; n = 0; clr = -1; run = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (tr[i].wr) begin
        if (n < 10) check("fips_wr", {tr[i].addr, tr[i].data}, fips_wr_exp(n, k, m));
        if (n == 9) clr = tr[i].cyc;
        n++;
      end else if (tr[i].addr == 4'd15) run++;
    end
    check("fips_wr_cnt", n, 10);
    check("fips_polls", run, 3);
    check("clr_before_rsp", (clr > 0) && (clr < at), 1);
    take_rsp(0);

    // Done never set: 4 polls, 2 idle cycles apart, then Start cleared and timeout response.
    done_delay[0] = -1;
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, acc);
    wait_rsp(0, 80, at);
    pc.delete(); n = 0;
    foreach (tr[i]) if (!tr[i].wr) begin n++; if (tr[i].addr == 4'd15) pc.push_back(tr[i].cyc); end
    check("to_reads", n, 4);
    check("to_polls", pc.size(), 4);
    for (int i = 1; i < pc.size(); i++) check("to_gap", pc[i] - pc[i-1], 3);
    last_poll = (pc.size() > 0) ? pc[pc.size()-1] : 0;
    if (tr.size() > 0) begin
      check("to_clr", {tr[tr.size()-1].wr, tr[tr.size()-1].addr, tr[tr.size()-1].data}, {1'b1, 4'd14, 32'd0});
      check("to_clr_cyc", tr[tr.size()-1].cyc - last_poll, 1);
    end
    check("to_latency", at - acc, 21);
    take_rsp(0);

    // Response back-pressure with a second command waiting.
    done_delay[0] = 0;
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    wait_rsp(0, 60, at);
    held = rsp_data[0];
    kb = {$urandom, $urandom, $urandom, $urandom};
    mb = {$urandom, $urandom, $urandom, $urandom};
    cmd_key[0] = kb; cmd_msg[0] = mb; cmd_valid[0] = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid[0] !== 1'b1 || rsp_data[0] !== held || rsp_timeout[0] !== 1'b0 ||
          cmd_ready[0] !== 1'b0 || cs[0] !== 1'b0) n++;
    end
    check("hold_stable", n, 0);
    take_rsp(0);
    check("ready_after_rsp", cmd_ready[0], 1);
    sb_q.push_back('{model_dec(kb, mb), 1'b0});
    acc = cyc;
    tr.delete();
    tick();
    cmd_valid[0] = 1'b0;
    check("second_first_wr", {cs[0], wr[0], addr[0], wdata[0]}, {1'b1, 1'b1, 4'd0, kb[127:96]});
    wait_rsp(0, 60, at);
    check("second_latency", at - acc, 16);
    take_rsp(0);

    // Reset while idling between polls, then a fresh command.
    done_delay[0] = -1;
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b1, acc);
    n = 0;
    while (!(rd[0] && addr[0] == 4'd15) && n < 40) begin tick(); n++; end
    check("saw_poll", rd[0] && addr[0] == 4'd15, 1);
    tick();
    check("in_poll_wait", {cs[0], busy[0]}, 2'b01);
    rst_n[0] = 1'b0;
    tick();
    check("mid_reset", {cs[0], rd[0], wr[0], busy[0], rsp_valid[0], cmd_ready[0]}, 0);
    tick();
    rst_n[0] = 1'b1;
    tick();
    if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
    done_delay[0] = 0;
    send(0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    wait_rsp(0, 60, at);
    check("post_reset_latency", at - acc, 16);
    take_rsp(0);

    // Read latency 2: every read address held 3 cycles.
    done_delay[1] = 0;
    send(1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    wait_rsp(1, 80, at);
    runs.delete(); run = 0; pa = -1; pcy = -10;
    foreach (tr[i]) if (!tr[i].wr) begin
      if (run > 0 && int'(tr[i].addr) == pa && tr[i].cyc == pcy + 1) run++;
      else begin
        if (run > 0) runs.push_back(run);
        run = 1;
      end
      pa = int'(tr[i].addr);
      pcy = tr[i].cyc;
    end
    if (run > 0) runs.push_back(run);
    check("rl2_runs", runs.size(), 5);
    foreach (runs[i]) check("rl2_hold", runs[i], 3);
    check("rl2_latency", at - acc, 26);
    take_rsp(1);

    check("bus_invariants", bad_inv, 0);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
